// File: rtl/hilo_md_if.sv
// Execute/Decode-side bundle of the HI/LO multiply/divide unit: op requests,
// operands, stall request and HI/LO forwarding outputs.
interface hilo_md_if #(
    parameter int WIDTH = 32
);
    logic [2:0]       md_op_e;
    logic [WIDTH-1:0] src_a_e;
    logic [WIDTH-1:0] src_b_e;
    logic [2:0]       md_op_d;
    logic             use_hilo_d;
    logic             busy;
    logic             md_stall_req;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;

    modport master (
        output md_op_e, src_a_e, src_b_e, md_op_d, use_hilo_d,
        input  busy, md_stall_req, done, div_by_zero, hi_out, lo_out
    );

    modport slave (
        input  md_op_e, src_a_e, src_b_e, md_op_d, use_hilo_d,
        output busy, md_stall_req, done, div_by_zero, hi_out, lo_out
    );
endinterface

// File: rtl/hilo_md_unit.sv
// Iterative mult/multu/div/divu unit owning HI/LO, with stall request for Decode.
// Optional macro MDU_EARLY_TERM_EN: multiply finishes once remaining multiplier bits are zero.
module hilo_md_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input logic     clk,
    input logic     rst_n,
    hilo_md_if.slave md
);
    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_RSVD  = 3'd7;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

`ifdef MDU_EARLY_TERM_EN
    localparam logic EARLY_TERM = 1'b1;
`else
    localparam logic EARLY_TERM = 1'b0;
`endif

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic en);
        return en ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic en);
        return en ? (~v + (2*WIDTH)'(1)) : v;
    endfunction

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] a_sh;
    logic [WIDTH-1:0]   b_reg;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   rem;
    logic               is_div;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;
    logic               dbz_q;

    logic signed [WIDTH-1:0] src_a_s;
    logic signed [WIDTH-1:0] src_b_s;
    logic                    op_signed;
    logic                    op_mul;
    logic                    op_dv;
    logic [WIDTH-1:0]        a_mag_in;
    logic [WIDTH-1:0]        b_mag_in;
    logic [WIDTH:0]          rem_sh;
    logic [WIDTH:0]          trial;
    logic                    last_iter;

    assign src_a_s   = md.src_a_e;
    assign src_b_s   = md.src_b_e;
    assign op_signed = (md.md_op_e == OP_MULT) || (md.md_op_e == OP_DIV);
    assign op_mul    = (md.md_op_e == OP_MULT) || (md.md_op_e == OP_MULTU);
    assign op_dv     = (md.md_op_e == OP_DIV)  || (md.md_op_e == OP_DIVU);
    assign a_mag_in  = neg_w(md.src_a_e, op_signed && (src_a_s < 0));
    assign b_mag_in  = neg_w(md.src_b_e, op_signed && (src_b_s < 0));

    // Restoring divide step: shift in the next dividend bit, then trial-subtract.
    assign rem_sh    = {rem, a_sh[WIDTH-1]};
    assign trial     = rem_sh - {1'b0, b_reg};
    assign last_iter = (cnt == '0) ||
                       (EARLY_TERM && !is_div && (b_reg[WIDTH-1:1] == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            a_sh   <= '0;
            b_reg  <= '0;
            acc    <= '0;
            rem    <= '0;
            is_div <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (md.md_op_e == OP_MTHI) begin
                        hi_q <= md.src_a_e;
                    end else if (md.md_op_e == OP_MTLO) begin
                        lo_q <= md.src_a_e;
                    end else if (op_dv && (md.src_b_e == '0)) begin
                        dbz_q <= 1'b1;
                    end else if (op_mul || op_dv) begin
                        a_sh   <= {{WIDTH{1'b0}}, a_mag_in};
                        b_reg  <= b_mag_in;
                        acc    <= '0;
                        rem    <= '0;
                        is_div <= op_dv;
                        sign_a <= op_signed && (src_a_s < 0);
                        sign_b <= op_signed && (src_b_s < 0);
                        cnt    <= CNT_W'(WIDTH - 1);
                        state  <= (EARLY_TERM && op_mul && (b_mag_in == '0)) ? FIX : CALC;
                    end
                end
                CALC: begin
                    if (is_div) begin
                        rem  <= trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
                        a_sh <= {a_sh[2*WIDTH-1:WIDTH], a_sh[WIDTH-2:0], ~trial[WIDTH]};
                    end else begin
                        if (b_reg[0]) begin
                            acc <= acc + a_sh;
                        end
                        a_sh  <= a_sh << 1;
                        b_reg <= b_reg >> 1;
                    end
                    if (last_iter) begin
                        state <= FIX;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                FIX: begin
                    if (is_div) begin
                        hi_q <= neg_w(rem, sign_a);
                        lo_q <= neg_w(a_sh[WIDTH-1:0], sign_a ^ sign_b);
                    end else begin
                        {hi_q, lo_q} <= neg_2w(acc, sign_a ^ sign_b);
                    end
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign md.busy         = (state != IDLE);
    assign md.md_stall_req = md.busy &&
                             (md.use_hilo_d || ((md.md_op_d != OP_NONE) && (md.md_op_d != OP_RSVD)));
    assign md.done         = done_q;
    assign md.div_by_zero  = dbz_q;
    assign md.hi_out       = hi_q;
    assign md.lo_out       = lo_q;
endmodule

// File: tb/tb_hilo_md_unit.sv
// Self-checking bench for hilo_md_unit: directed corner cases plus random ops
// against an arithmetic reference model.
module tb_hilo_md_unit;
    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

`ifdef MDU_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    hilo_md_if #(.WIDTH(32)) ifc ();

    hilo_md_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .md    (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {hi, lo} from plain integer arithmetic.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        res = '0;
        case (op)
            OP_MULT:  res = 64'(sa * sb);
            OP_MULTU: res = {32'd0, a} * {32'd0, b};
            OP_DIV: begin
                q = sa / sb;
                r = sa % sb;
                res = {r[31:0], q[31:0]};
            end
            OP_DIVU:  res = {a % b, a / b};
            default:  res = '0;
        endcase
        return res;
    endfunction

    function automatic int exp_busy(input logic [2:0] op, input logic [31:0] b);
        logic [31:0] mag;
        int k;
        if (!EARLY || !(op == OP_MULT || op == OP_MULTU)) return 33;
        mag = (op == OP_MULT && b[31]) ? (32'd0 - b) : b;
        if (mag == 0) return 1;
        k = 0;
        for (int i = 0; i < 32; i++) if (mag[i]) k = i;
        return k + 2;
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit poke);
        logic [63:0] pre, exp;
        int cycles;
        pre = {ifc.hi_out, ifc.lo_out};
        exp = model(op, a, b);
        @(negedge clk);
        ifc.md_op_e = op;
        ifc.src_a_e = a;
        ifc.src_b_e = b;
        @(negedge clk);
        ifc.md_op_e = OP_NONE;
        cycles = 0;
        while (ifc.busy === 1'b1 && cycles < 100) begin
            cycles++;
            chk("hilo_stable", {ifc.hi_out, ifc.lo_out}, pre);
            if (poke && cycles == 5) begin
                ifc.use_hilo_d = 1'b1;
                #1 chk("stall_use_hilo", 64'(ifc.md_stall_req), 64'd1);
                ifc.use_hilo_d = 1'b0;
                ifc.md_op_d = OP_DIV;
                #1 chk("stall_md_op_d", 64'(ifc.md_stall_req), 64'd1);
                ifc.md_op_d = OP_NONE;
                #1 chk("no_stall", 64'(ifc.md_stall_req), 64'd0);
                ifc.md_op_e = OP_MTHI;
                ifc.src_a_e = 32'h1234;
            end
            if (poke && cycles == 6) ifc.md_op_e = OP_NONE;
            @(negedge clk);
        end
        chk("busy_cycles", 64'(cycles), 64'(exp_busy(op, b)));
        chk("done_pulse", 64'(ifc.done), 64'd1);
        chk("hi_result", 64'(ifc.hi_out), 64'(exp[63:32]));
        chk("lo_result", 64'(ifc.lo_out), 64'(exp[31:0]));
        chk("idle_stall", 64'(ifc.md_stall_req), 64'd0);
        @(negedge clk);
        chk("done_clear", 64'(ifc.done), 64'd0);
    endtask

    task automatic run_dbz(input logic [2:0] op, input logic [31:0] a);
        logic [63:0] pre;
        pre = {ifc.hi_out, ifc.lo_out};
        @(negedge clk);
        ifc.md_op_e = op;
        ifc.src_a_e = a;
        ifc.src_b_e = 32'd0;
        @(negedge clk);
        ifc.md_op_e = OP_NONE;
        chk("dbz_pulse", 64'(ifc.div_by_zero), 64'd1);
        chk("dbz_not_busy", 64'(ifc.busy), 64'd0);
        chk("dbz_hilo_kept", {ifc.hi_out, ifc.lo_out}, pre);
        @(negedge clk);
        chk("dbz_clear", 64'(ifc.div_by_zero), 64'd0);
    endtask

    task automatic run_mt(input logic [2:0] op, input logic [31:0] a);
        logic [63:0] exp;
        exp = (op == OP_MTHI) ? {a, ifc.lo_out} : {ifc.hi_out, a};
        @(negedge clk);
        ifc.md_op_e = op;
        ifc.src_a_e = a;
        @(negedge clk);
        ifc.md_op_e = OP_NONE;
        chk("mt_hilo", {ifc.hi_out, ifc.lo_out}, exp);
        chk("mt_not_busy", 64'(ifc.busy), 64'd0);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        n_chk = 0;
        n_fail = 0;
        rst_n = 1'b0;
        ifc.md_op_e = OP_NONE;
        ifc.src_a_e = '0;
        ifc.src_b_e = '0;
        ifc.md_op_d = OP_NONE;
        ifc.use_hilo_d = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_hilo", {ifc.hi_out, ifc.lo_out}, 64'd0);
        chk("rst_flags", {61'd0, ifc.busy, ifc.done, ifc.div_by_zero}, 64'd0);
        rst_n = 1'b1;

        run_op(OP_MULT,  32'hFFFF_FFFE, 32'd3, 1'b1);
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("div_neg_lo", 64'(ifc.lo_out), 64'h0000_0000_FFFF_FFFD);
        chk("div_neg_hi", 64'(ifc.hi_out), 64'h0000_0000_FFFF_FFFF);
        run_op(OP_DIVU,  32'd100, 32'd7, 1'b0);
        chk("divu_lo", 64'(ifc.lo_out), 64'd14);
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("div_ovf_lo", 64'(ifc.lo_out), 64'h8000_0000);
        run_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, 1'b0);
        chk("mult_min_hilo", {ifc.hi_out, ifc.lo_out}, 64'h4000_0000_0000_0000);
        run_op(OP_MULT,  32'h1234_5678, 32'd0, 1'b0);
        run_dbz(OP_DIVU, 32'd5);
        run_dbz(OP_DIV,  32'hDEAD_BEEF);
        run_mt(OP_MTHI, 32'h1234);
        run_mt(OP_MTLO, 32'hABCD);

        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(1, 4));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            if ((op == OP_DIV || op == OP_DIVU) && b == 0) run_dbz(op, a);
            else run_op(op, a, b, 1'b0);
        end

        // Abort a multiply mid-flight with reset.
        @(negedge clk);
        ifc.md_op_e = OP_MULTU;
        ifc.src_a_e = 32'hFFFF_FFFF;
        ifc.src_b_e = 32'hFFFF_FFFF;
        @(negedge clk);
        ifc.md_op_e = OP_NONE;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_hilo", {ifc.hi_out, ifc.lo_out}, 64'd0);
        chk("abort_flags", {61'd0, ifc.busy, ifc.done, ifc.div_by_zero}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(OP_MULT, 32'd6, 32'd7, 1'b0);
        chk("mult_6x7", {ifc.hi_out, ifc.lo_out}, 64'd42);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
